// File: rtl/uart_param.sv
// Parametrised full-duplex UART: valid/ready transmitter and an oversampling-free
// mid-bit receiver with synchroniser, false-start rejection and error flags.
module uart_param #(
  parameter int CLOCK_HZ  = 80000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_TX_Valid,
  input  logic [DATA_BITS-1:0] i_TX_Data,
  output logic                 o_TX_Ready,
  output logic                 o_TX,
  output logic                 o_TX_Busy,
  input  logic                 i_RX,
  output logic                 o_RX_Valid,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_RX_Parity_Err,
  output logic                 o_RX_Frame_Err
);

  localparam int DIVIDER = CLOCK_HZ / BAUD;
  localparam int CW      = $clog2(DIVIDER);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] MID_LAST  = CW'(DIVIDER / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);

  // Line value of the parity bit for a word (odd mode inverts the XOR).
  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_last;

  assign tx_last = (tx_cnt_q == BIT_LAST);

  // tx_d is the line level for the state being entered, so o_TX is a clean flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_state_q == TX_IDLE || tx_last) ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: if (i_TX_Valid) begin
        tx_state_d = TX_START;
        tx_shift_d = i_TX_Data;
        tx_par_d   = par_of(i_TX_Data);
        tx_d       = 1'b0;
      end
      TX_START: if (tx_last) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_last) begin
        if (tx_bit_q == DATA_LAST) begin
          tx_bit_d = '0;
          if (HAS_PAR) begin
            tx_state_d = TX_PAR;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PAR: if (tx_last) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = '0;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_last) begin
        if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
        else                       tx_bit_d   = tx_bit_q + 4'd1;
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign o_TX       = tx_q;
  assign o_TX_Ready = (tx_state_q == TX_IDLE);
  assign o_TX_Busy  = (tx_state_q != TX_IDLE);

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic                 rx_last;

  assign rx_last = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_meta_d  = i_RX;
    rx_s_d     = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = (rx_state_q == RX_IDLE || rx_state_q == RX_WAIT_HIGH || rx_last)
                 ? '0 : rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    case (rx_state_q)
      RX_IDLE: if (!rx_s_q) rx_state_d = RX_START;
      // Half-bit check rejects glitches; later samples land mid-bit.
      RX_START: if (rx_cnt_q == MID_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_last) begin
        rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
        else                       rx_bit_d   = rx_bit_q + 4'd1;
      end
      RX_PAR: if (rx_last) begin
        rx_par_d   = rx_s_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_last) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
        rx_perr_d  = HAS_PAR && (rx_par_q != par_of(rx_shift_q));
        rx_ferr_d  = ~rx_s_q;
        rx_state_d = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign o_RX_Valid      = rx_valid_q;
  assign o_RX_Data       = rx_data_q;
  assign o_RX_Parity_Err = rx_perr_q;
  assign o_RX_Frame_Err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance (0) and an 8E1 instance (1) at DIVIDER=16,
// checked against a bit-list line model and a queue of received words.
module tb_uart_param;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid [2], tx_ready [2], tx_line [2], tx_busy [2];
  logic       rx_in [2], rx_drv [2], loop [2];
  logic       rx_valid [2], rx_perr [2], rx_ferr [2];
  logic [7:0] tx_data [2], rx_data [2];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int k; logic [7:0] d; logic pe; logic fe; } rx_ev_t;
  rx_ev_t rxq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign rx_in[g] = loop[g] ? tx_line[g] : rx_drv[g];
    uart_param #(.CLOCK_HZ(1600000), .BAUD(100000), .DATA_BITS(8),
                 .PARITY(g == 0 ? 0 : 2), .STOP_BITS(1)) u_dut (
      .i_Clock(clk), .i_Reset(rst),
      .i_TX_Valid(tx_valid[g]), .i_TX_Data(tx_data[g]), .o_TX_Ready(tx_ready[g]),
      .o_TX(tx_line[g]), .o_TX_Busy(tx_busy[g]), .i_RX(rx_in[g]),
      .o_RX_Valid(rx_valid[g]), .o_RX_Data(rx_data[g]),
      .o_RX_Parity_Err(rx_perr[g]), .o_RX_Frame_Err(rx_ferr[g]));
    always @(negedge clk)
      if (rx_valid[g]) rxq.push_back(rx_ev_t'{k: g, d: rx_data[g], pe: rx_perr[g], fe: rx_ferr[g]});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: a frame is a list of line levels, one per bit time
  function automatic int pmode(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic par_bit(int k, logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (pmode(k) == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic int frame_len(int k);
    return 1 + 8 + ((pmode(k) != 0) ? 1 : 0) + 1;
  endfunction

  function automatic logic line_bit(int k, logic [7:0] d, int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pmode(k) != 0 && b == 9) return par_bit(k, d);
    return 1'b1;
  endfunction

  function automatic int find_ev(int k);
    foreach (rxq[i]) if (rxq[i].k == k) return i;
    return -1;
  endfunction

  function automatic int count_k(int k);
    int n = 0;
    foreach (rxq[i]) if (rxq[i].k == k) n++;
    return n;
  endfunction

  // Called at the negedge of the first start-bit cycle; returns at the negedge after the frame.
  task automatic tx_expect(int k, logic [7:0] d);
    for (int c = 0; c < frame_len(k) * DIV; c++) begin
      check("tx_line", tx_line[k], line_bit(k, d, c / DIV));
      check("tx_ready_low", tx_ready[k], 0);
      check("tx_busy_high", tx_busy[k], 1);
      @(negedge clk);
    end
    check("tx_ready_back", tx_ready[k], 1);
    check("tx_busy_clear", tx_busy[k], 0);
  endtask

  task automatic tx_send(int k, logic [7:0] d);
    for (int i = 0; i < 400 && !tx_ready[k]; i++) @(negedge clk);
    check("tx_ready_wait", tx_ready[k], 1);
    tx_valid[k] = 1'b1;
    tx_data[k]  = d;
    @(negedge clk);
    tx_valid[k] = 1'b0;
    tx_data[k]  = 8'($urandom);
    tx_expect(k, d);
  endtask

  task automatic rx_send(int k, logic [7:0] d, logic flip, logic stopv, int hold);
    for (int b = 0; b < frame_len(k); b++) begin
      logic v;
      v = line_bit(k, d, b);
      if (pmode(k) != 0 && b == 9) v = v ^ flip;
      if (b == frame_len(k) - 1) v = stopv;
      rx_drv[k] = v;
      repeat (DIV) @(negedge clk);
    end
    if (!stopv) repeat (hold) @(negedge clk);
    rx_drv[k] = 1'b1;
  endtask

  task automatic rx_expect(int k, logic [7:0] d, logic pe, logic fe);
    int idx = -1;
    rx_ev_t ev;
    for (int t = 0; t <= 4 * DIV && idx < 0; t++) begin
      idx = find_ev(k);
      if (idx < 0) @(negedge clk);
    end
    check("rx_pulse_seen", idx >= 0, 1);
    if (idx >= 0) begin
      ev = rxq[idx];
      rxq.delete(idx);
      check("rx_data", ev.d, d);
      check("rx_parity_err", ev.pe, pe);
      check("rx_frame_err", ev.fe, fe);
      check("rx_data_hold", rx_data[k], d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] dt, dr;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tx_valid[k] = 1'b0; tx_data[k] = 8'h00; rx_drv[k] = 1'b1; loop[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_tx", tx_line[k], 1);
      check("rst_ready", tx_ready[k], 1);
      check("rst_busy", tx_busy[k], 0);
      check("rst_rx_valid", rx_valid[k], 0);
      check("rst_rx_data", rx_data[k], 0);
      check("rst_perr", rx_perr[k], 0);
      check("rst_ferr", rx_ferr[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 8N1 single word; ready must return exactly 160 cycles after start
    tx_send(0, 8'hA5);

    // back-to-back with valid held: second start bit 161 cycles after the first
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h55;
    @(negedge clk);
    tx_data[0]  = 8'h0F;
    tx_expect(0, 8'h55);
    check("b2b_gap_high", tx_line[0], 1);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    tx_expect(0, 8'h0F);

    // 8E1 loopback
    loop[1] = 1'b1;
    tx_send(1, 8'h37);
    rx_expect(1, 8'h37, 1'b0, 1'b0);
    loop[1] = 1'b0;

    // parity error, then frame error with a long break
    repeat (4) @(negedge clk);
    rx_send(1, 8'h37, 1'b1, 1'b1, 0);
    rx_expect(1, 8'h37, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    dr = 8'($urandom);
    rx_send(1, dr, 1'b0, 1'b0, 200);
    rx_expect(1, dr, 1'b0, 1'b1);
    check("wait_high_no_restart", count_k(1), 0);
    repeat (DIV) @(negedge clk);
    dr = 8'($urandom);
    rx_send(1, dr, 1'b0, 1'b1, 0);
    rx_expect(1, dr, 1'b0, 1'b0);

    // false start
    rx_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("false_start_no_pulse", count_k(0), 0);
    rx_send(0, 8'h81, 1'b0, 1'b1, 0);
    rx_expect(0, 8'h81, 1'b0, 1'b0);

    // reset mid-frame: TX in data bit 3, RX in data bit 4
    dt = 8'($urandom);
    dr = 8'($urandom);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 86; c++) begin
      rx_drv[0] = line_bit(0, dr, c / DIV);
      if (c == 15) begin tx_valid[0] = 1'b1; tx_data[0] = dt; end
      if (c == 16) tx_valid[0] = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    rx_drv[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx_line[0], 1);
    check("midrst_ready", tx_ready[0], 1);
    check("midrst_busy", tx_busy[0], 0);
    check("midrst_rx_data", rx_data[0], 0);
    repeat (2 * 10 * DIV) @(negedge clk);
    check("midrst_no_pulse", count_k(0), 0);
    loop[0] = 1'b1;
    tx_send(0, 8'hC3);
    rx_expect(0, 8'hC3, 1'b0, 1'b0);
    loop[0] = 1'b0;

    // randomized full-duplex traffic with error injection
    for (int it = 0; it < 16; it++) begin
      int   k, hold;
      logic flip, stopv;
      k     = int'($urandom_range(0, 1));
      dt    = 8'($urandom);
      dr    = 8'($urandom);
      flip  = ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 3) != 0);
      hold  = stopv ? 0 : int'($urandom_range(1, 40));
      repeat ($urandom_range(2, 20)) @(negedge clk);
      fork
        tx_send(k, dt);
        rx_send(k, dr, flip, stopv, hold);
      join
      rx_expect(k, dr, flip && (pmode(k) != 0), !stopv);
    end

    repeat (3 * DIV) @(negedge clk);
    check("no_extra_pulses", rxq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART that replaces the fixed 8N1 / 115200 block.
- Baud divider, data width, parity mode and stop-bit count are set by parameters.
- Adds a valid/ready TX handshake, an RX input synchroniser, false-start rejection, and parity and framing error flags.
- Runs entirely in the i_Clock domain with no derived clocks. Sits between the LED/control logic and the board UART pins.

Parameters:
- CLOCK_HZ, 80000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIVIDER = CLOCK_HZ/BAUD (integer, truncated); must be at least 8.
- DATA_BITS, 8, payload bits per frame (5..9).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted (1 or 2).

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_TX_Valid  in  1  TX data valid.
- i_TX_Data  in  DATA_BITS  byte to send.
- o_TX_Ready  out  1  transmitter can accept a word.
- o_TX  out  1  serial output; idles high.
- o_TX_Busy  out  1  frame in progress.
- i_RX  in  1  asynchronous serial input.
- o_RX_Valid  out  1  one-cycle pulse: word received.
- o_RX_Data  out  DATA_BITS  last received word.
- o_RX_Parity_Err  out  1  parity mismatch on last word.
- o_RX_Frame_Err  out  1  stop bit sampled low on last word.

Behaviour:
- Clock and reset: one clock, i_Clock. Reset is synchronous and active-high on i_Reset.
- Reset values: o_TX=1, o_TX_Ready=1, o_TX_Busy=0, o_RX_Valid=0, o_RX_Data=0, both error flags 0. Synchroniser flops reset to 1.
- Reset mid-operation: both state machines return to IDLE on the next edge and any partial frame is abandoned. i_TX_Valid is ignored while i_Reset is high.

TX state machine: IDLE, START, DATA, PARITY, STOP.
- Bit timer counts 0..DIVIDER-1, so every bit lasts exactly DIVIDER cycles.
- Handshake: accept occurs on an edge where i_TX_Valid && o_TX_Ready.
- On accept: i_TX_Data is latched, o_TX_Ready=0 and o_TX_Busy=1 from the next cycle, and o_TX goes low (start bit) on that same cycle.
- DATA: bits are sent LSB first.
- PARITY: entered only if PARITY!=0. Even: parity bit = XOR of data. Odd: parity bit = inverted XOR of data.
- STOP: STOP_BITS x DIVIDER cycles of o_TX=1. At the end, return to IDLE with o_TX_Ready=1 and o_TX_Busy=0.
- Frame length is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) x DIVIDER cycles.
- Back-to-back: if i_TX_Valid is held high, the next start bit begins on the cycle after the last stop-bit cycle, with no idle gap beyond one accept cycle.
- i_TX_Data changes outside the accept edge have no effect on the frame in flight.

RX path:
- i_RX passes through a 2-flop synchroniser (rx_s). All RX decisions use rx_s.
- RX states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE -> START when rx_s=0. START samples at count DIVIDER/2-1. If rx_s=1 at that sample, the start is false: return to IDLE with no pulse.
- Subsequent samples are taken every DIVIDER cycles from the start-bit midpoint: DATA (LSB first), then PARITY if enabled, then the first stop bit only. A second stop bit is not checked.
- On the cycle after the stop sample:
  - o_RX_Valid=1 for exactly one cycle.
  - o_RX_Data is updated.
  - o_RX_Parity_Err is set if the sampled parity differs from the computed parity; it is always 0 when PARITY=0.
  - o_RX_Frame_Err = (stop sample == 0).
- o_RX_Data and both flags hold their values until the next o_RX_Valid.
- A word with errors still pulses o_RX_Valid.
- Frame error handling: the FSM goes to WAIT_HIGH and stays there until rx_s=1. This covers the break condition.
- Otherwise the FSM returns straight to IDLE, so a new start bit can be detected during the sender's remaining stop time.
- TX and RX are fully independent; simultaneous activity is allowed.

Test Plan:
- All tests use CLOCK_HZ=1600000, BAUD=100000 (DIVIDER=16).
- TX 8N1: send 0xA5 -> o_TX low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high 16 cycles. o_TX_Ready returns to 1 exactly 160 cycles after the start bit began.
- TX back-to-back: 8N1, i_TX_Valid held with 0x55 then 0x0F -> second start bit falls exactly 161 cycles after the first start edge, and o_TX shows no glitch.
- RX even parity loopback: PARITY=2, o_TX tied to i_RX, send 0x37 -> parity bit on the line is 1. o_RX_Valid pulses once with o_RX_Data=0x37 and both error flags 0.
- RX errors, 8E1: inject 0x37 with parity bit 0 -> o_RX_Parity_Err=1. Inject a frame with the stop bit low -> o_RX_Frame_Err=1; no new start is detected until i_RX returns high.
- False start: i_RX low for 4 cycles, then high -> no o_RX_Valid and the FSM is back in IDLE. A valid 0x81 frame immediately afterwards is received correctly.
- Reset mid-frame: assert i_Reset for 1 cycle during TX bit 3 and RX bit 4 -> next cycle o_TX=1, o_TX_Ready=1, no o_RX_Valid pulse. A subsequent 0xC3 frame transmits and receives correctly.
